// File: rtl/riot_input_conditioner_if.sv
// Level-only bus between the raw console controls and the RIOT input conditioner.
// No handshake: raw inputs are free-running levels, PA/PB/changed are registered levels.
interface riot_input_conditioner_if;
  logic [3:0] joy0;
  logic [3:0] joy1;
  logic       sw_reset;
  logic       sw_select;
  logic       sw_pause;
  logic       diff_l;
  logic       diff_r;
  logic       inhibit;
  logic [7:0] PA;
  logic [7:0] PB;
  logic       changed;

  modport master (
    output joy0, joy1, sw_reset, sw_select, sw_pause, diff_l, diff_r, inhibit,
    input  PA, PB, changed
  );

  modport slave (
    input  joy0, joy1, sw_reset, sw_select, sw_pause, diff_l, diff_r, inhibit,
    output PA, PB, changed
  );
endinterface

// File: rtl/riot_input_conditioner.sv
// Synchronise, debounce and map console switches/joysticks onto RIOT PAin/PBin.
// Optional macro JOY_SOCD_EN: opposing joystick directions both pressed read as released.
module riot_input_conditioner #(
  parameter int unsigned TICK_DIV   = 1790,
  parameter int unsigned DB_SAMPLES = 4
) (
  input logic                     CLK,
  input logic                     RES,
  riot_input_conditioner_if.slave bus
);

  localparam int          N         = 13;
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [3:0]  RUN_LAST  = 4'(DB_SAMPLES - 1);

  logic [15:0] r_tick_cnt;
  logic        w_tick;
  logic [N-1:0] w_raw;
  logic [N-1:0] r_sync1;
  logic [N-1:0] r_sync2;
  logic [N-1:0] r_stable;
  logic [3:0]   r_run [N];
  logic [3:0]   w_joy0;
  logic [3:0]   w_joy1;
  logic [7:0]   w_pa;
  logic [7:0]   w_pb;
  logic [7:0]   r_pa;
  logic [7:0]   r_pb;
  logic         r_changed;

  // Bit order: [3:0] joy0 {R,L,D,U}, [7:4] joy1, 8 reset, 9 select, 10 pause, 11 diff_l, 12 diff_r
  assign w_raw  = {bus.diff_r, bus.diff_l, bus.sw_pause, bus.sw_select, bus.sw_reset,
                   bus.joy1, bus.joy0};
  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A differing bit must be seen on DB_SAMPLES consecutive ticks; any agreeing tick restarts the run.
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_stable <= '0;
      for (int i = 0; i < N; i++) r_run[i] <= '0;
    end else if (w_tick) begin
      for (int i = 0; i < N; i++) begin
        if (r_sync2[i] != r_stable[i]) begin
          if (r_run[i] == RUN_LAST) begin
            r_stable[i] <= r_sync2[i];
            r_run[i]    <= '0;
          end else begin
            r_run[i] <= r_run[i] + 4'd1;
          end
        end else begin
          r_run[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    w_joy0 = r_stable[3:0];
    w_joy1 = r_stable[7:4];
`ifdef JOY_SOCD_EN
    if (r_stable[0] && r_stable[1]) w_joy0[1:0] = 2'b00;
    if (r_stable[2] && r_stable[3]) w_joy0[3:2] = 2'b00;
    if (r_stable[4] && r_stable[5]) w_joy1[1:0] = 2'b00;
    if (r_stable[6] && r_stable[7]) w_joy1[3:2] = 2'b00;
`endif
  end

  // Difficulty bits bypass inhibit; PB[2], PB[4], PB[5] are RIOT-driven and read as 1.
  always_comb begin
    w_pa = bus.inhibit ? 8'hFF : {~w_joy0, ~w_joy1};
    w_pb = {r_stable[12], r_stable[11], 1'b1, 1'b1,
            ~r_stable[10] | bus.inhibit, 1'b1,
            ~r_stable[9]  | bus.inhibit,
            ~r_stable[8]  | bus.inhibit};
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_pa      <= 8'hFF;
      r_pb      <= 8'h3F;
      r_changed <= 1'b0;
    end else begin
      r_pa      <= w_pa;
      r_pb      <= w_pb;
      r_changed <= (w_pa != r_pa) || (w_pb != r_pb);
    end
  end

  assign bus.PA      = r_pa;
  assign bus.PB      = r_pb;
  assign bus.changed = r_changed;

endmodule

// File: tb/tb_riot_input_conditioner.sv
// Directed bench for riot_input_conditioner with TICK_DIV=4, DB_SAMPLES=3.
// Every changed pulse is checked against an expected {PA,PB} queue.
module tb_riot_input_conditioner;

  logic CLK;
  logic RES;
  int   n_vec;
  int   n_miss;
  logic [15:0] exp_q[$];

  riot_input_conditioner_if bus ();

  riot_input_conditioner #(
    .TICK_DIV   (4),
    .DB_SAMPLES (3)
  ) dut (
    .CLK (CLK),
    .RES (RES),
    .bus (bus.slave)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic hold_out(input string tag, input logic [7:0] pa, input logic [7:0] pb, input int n);
    for (int i = 0; i < n; i++) begin
      step(1);
      check_vec(tag, {bus.PA, bus.PB}, {pa, pb});
    end
  endtask

  task automatic wait_out(input string tag, input logic [7:0] pa, input logic [7:0] pb, input int max_clk);
    for (int i = 0; i < max_clk; i++) begin
      step(1);
      if ({bus.PA, bus.PB} === {pa, pb}) break;
    end
    check_vec(tag, {bus.PA, bus.PB}, {pa, pb});
  endtask

  // scoreboard: each changed pulse must match the next expected {PA,PB}
  always @(negedge CLK) begin
    if (bus.changed === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_vec("changed_spurious", {bus.PA, bus.PB}, 32'h0);
      end else begin
        check_vec("changed_value", {bus.PA, bus.PB}, exp_q.pop_front());
      end
    end
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    RES    = 1'b1;
    bus.joy0 = 4'b0; bus.joy1 = 4'b0;
    bus.sw_reset = 1'b0; bus.sw_select = 1'b0; bus.sw_pause = 1'b0;
    bus.diff_l = 1'b0; bus.diff_r = 1'b0; bus.inhibit = 1'b0;

    step(3);
    check_vec("reset_pa", bus.PA, 8'hFF);
    check_vec("reset_pb", bus.PB, 8'h3F);
    check_vec("reset_changed", bus.changed, 1'b0);
    RES = 1'b0;
    hold_out("idle", 8'hFF, 8'h3F, 20);

    // joystick 0 up
    exp_q.push_back({8'hEF, 8'h3F});
    bus.joy0 = 4'b0001;
    wait_out("joy0_up", 8'hEF, 8'h3F, 15);
    hold_out("joy0_up_hold", 8'hEF, 8'h3F, 5);

    // short console reset press is rejected, long one accepted
    bus.sw_reset = 1'b1;
    step(6);
    bus.sw_reset = 1'b0;
    hold_out("bounce_rejected", 8'hEF, 8'h3F, 20);
    exp_q.push_back({8'hEF, 8'h3E});
    bus.sw_reset = 1'b1;
    step(16);
    bus.sw_reset = 1'b0;
    check_vec("sw_reset_pb", bus.PB, 8'h3E);
    exp_q.push_back({8'hEF, 8'h3F});
    wait_out("sw_reset_release", 8'hEF, 8'h3F, 15);

    // difficulty then pause
    exp_q.push_back({8'hEF, 8'hFF});
    bus.diff_l = 1'b1;
    bus.diff_r = 1'b1;
    wait_out("diff_both", 8'hEF, 8'hFF, 15);
    exp_q.push_back({8'hEF, 8'hF7});
    bus.sw_pause = 1'b1;
    wait_out("pause", 8'hEF, 8'hF7, 15);

    // inhibit with joystick 1 left held
    exp_q.push_back({8'hFF, 8'hF7});
    bus.joy0 = 4'b0000;
    wait_out("joy0_release", 8'hFF, 8'hF7, 15);
    exp_q.push_back({8'hFB, 8'hF7});
    bus.joy1 = 4'b0100;
    wait_out("joy1_left", 8'hFB, 8'hF7, 15);
    step(2);
    exp_q.push_back({8'hFF, 8'hFF});
    bus.inhibit = 1'b1;
    step(1);
    check_vec("inhibit_on", {bus.PA, bus.PB}, {8'hFF, 8'hFF});
    hold_out("inhibit_hold", 8'hFF, 8'hFF, 3);
    exp_q.push_back({8'hFB, 8'hF7});
    bus.inhibit = 1'b0;
    step(1);
    check_vec("inhibit_off", {bus.PA, bus.PB}, {8'hFB, 8'hF7});

    // opposing directions on joystick 0
    exp_q.push_back({8'hFF, 8'hF7});
    bus.joy1 = 4'b0000;
    wait_out("joy1_release", 8'hFF, 8'hF7, 15);
    bus.joy0 = 4'b0011;
`ifdef JOY_SOCD_EN
    hold_out("socd_filtered", 8'hFF, 8'hF7, 20);
`else
    exp_q.push_back({8'hCF, 8'hF7});
    wait_out("socd_passthru", 8'hCF, 8'hF7, 15);
    hold_out("socd_passthru_hold", 8'hCF, 8'hF7, 3);
`endif

    // reset in the middle of a joystick 1 right debounce
    bus.joy1 = 4'b1000;
    step(6);
    RES = 1'b1;
    bus.joy0 = 4'b0000;
    bus.sw_pause = 1'b0;
    bus.diff_l = 1'b0;
    bus.diff_r = 1'b0;
    step(2);
    check_vec("midrun_reset_out", {bus.PA, bus.PB}, {8'hFF, 8'h3F});
    check_vec("midrun_reset_changed", bus.changed, 1'b0);
    exp_q.push_back({8'hF7, 8'h3F});
    RES = 1'b0;
    hold_out("fresh_run_hold", 8'hFF, 8'h3F, 12);
    step(1);
    check_vec("fresh_run_done", {bus.PA, bus.PB}, {8'hF7, 8'h3F});
    step(3);

    check_vec("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
